// File: rtl/line_data_memory_if.sv
// Line request/response bus between the data cache controller and the line memory.
// The controller holds enable until it sees ack; the memory answers with one ack cycle.
interface line_data_memory_if;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         enable;
    logic         write;
    logic         ack;
    logic [255:0] rdata;

    modport master (
        output addr,
        output wdata,
        output enable,
        output write,
        input  ack,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  enable,
        input  write,
        output ack,
        output rdata
    );
endinterface

// File: rtl/line_data_memory.sv
// Line-granular main-memory model: one 256-bit line request at a time,
// serviced after LATENCY cycles and acknowledged for exactly one cycle.
module line_data_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned DEPTH   = 512
) (
    input  logic              clk,
    input  logic              rst,
    line_data_memory_if.slave bus
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         count;
    logic [7:0]         count_next;

    logic [IDX_W-1:0]   idx_q;
    logic [255:0]       wdata_q;
    logic               write_q;

    logic               ack_q;
    logic [255:0]       rdata_q;

    logic [255:0]       mem [DEPTH];

    logic [IDX_W-1:0]   req_idx;
    logic               accept;
    logic               access;
    logic [IDX_W-1:0]   acc_idx;
    logic [255:0]       acc_wdata;
    logic               acc_write;

    // Offset bits and the aliased upper bits play no part in addressing.
    logic               unused_addr_bits;

    assign req_idx          = bus.addr[IDX_W+4:5];
    assign unused_addr_bits = ^{bus.addr[31:IDX_W+5], bus.addr[4:0]};

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        access     = 1'b0;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        acc_write  = write_q;

        case (state)
            IDLE: begin
                if (bus.enable) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: the access happens on the accepting
                        // edge itself, straight from the bus rather than the latches.
                        access     = 1'b1;
                        acc_idx    = req_idx;
                        acc_wdata  = bus.wdata;
                        acc_write  = bus.write;
                        count_next = '0;
                        state_next = ACK;
                    end else begin
                        count_next = CNT_LOAD;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (count == '0) begin
                    access     = 1'b1;
                    state_next = ACK;
                end else begin
                    count_next = count - 8'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            ack_q <= (state_next == ACK);
            if (accept) begin
                idx_q   <= req_idx;
                wdata_q <= bus.wdata;
                write_q <= bus.write;
            end
            if (access && !acc_write) begin
                rdata_q <= mem[acc_idx];
            end
        end
    end

    // The array has no reset; a write caught by reset must not land.
    always_ff @(posedge clk) begin
        if (access && acc_write && !rst) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_line_data_memory.sv
// Directed bench for line_data_memory: latency, write/read, busy-ignore,
// aliasing, held enable and reset during a pending write.
module tb_line_data_memory;

    localparam int unsigned LATENCY = 10;
    localparam int unsigned DEPTH   = 512;

    localparam logic [255:0] PAT_A5  = {32{8'hA5}};
    localparam logic [255:0] PAT_12  = {4{64'h1234_5678_9ABC_DEF0}};
    localparam logic [255:0] PAT_C3  = {32{8'hC3}};
    localparam logic [255:0] PAT_77  = {32{8'h77}};
    localparam logic [255:0] PAT_FF  = {32{8'hFF}};

    logic clk;
    logic rst;

    line_data_memory_if bus();

    line_data_memory #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, drop enable after acceptance and watch a bounded window.
    task automatic transact(input logic [31:0] a, input logic [255:0] d, input logic wr,
                            input bit disturb, output logic [255:0] rd,
                            output int first_ack, output int n_ack);
        bus.addr   = a;
        bus.wdata  = d;
        bus.write  = wr;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        first_ack  = -1;
        n_ack      = 0;
        rd         = '0;
        for (int k = 1; k <= int'(LATENCY) + 4; k++) begin
            if (disturb && k < int'(LATENCY)) begin
                bus.enable = (k % 2 == 1);
                bus.addr   = $urandom;
                bus.write  = ~wr;
                bus.wdata  = {8{$urandom}};
            end else begin
                bus.enable = 1'b0;
            end
            tick();
            if (bus.ack === 1'b1) begin
                n_ack++;
                if (first_ack < 0) begin
                    first_ack = k;
                    rd        = bus.rdata;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rd;
        int           first_ack;
        int           n_ack;
        int           acks_after;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.write  = 1'b0;
        bus.enable = 1'b0;

        // Reset asserted between edges takes effect without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_eq("reset_ack", 256'(bus.ack), 256'(0));
        check_eq("reset_rdata", bus.rdata, '0);
        @(posedge clk);
        tick();
        rst = 1'b0;
        tick();
        check_eq("idle_ack", 256'(bus.ack), 256'(0));

        // Preload line 3; data_o still holds its reset value through the write ack.
        transact(32'h0000_0060, PAT_A5, 1'b1, 1'b0, rd, first_ack, n_ack);
        check_eq("preload_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("preload_nack", 256'(n_ack), 256'(1));
        check_eq("preload_rdata_hold", rd, '0);

        transact(32'h0000_0060, '0, 1'b0, 1'b0, rd, first_ack, n_ack);
        check_eq("read_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("read_nack", 256'(n_ack), 256'(1));
        check_eq("read_data", rd, PAT_A5);

        transact(32'h0000_0080, PAT_12, 1'b1, 1'b0, rd, first_ack, n_ack);
        check_eq("write_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("write_nack", 256'(n_ack), 256'(1));
        check_eq("write_rdata_hold", rd, PAT_A5);
        check_eq("write_array", dut.mem[4], PAT_12);

        transact(32'h0000_0080, '0, 1'b0, 1'b0, rd, first_ack, n_ack);
        check_eq("rdback_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("rdback_data", rd, PAT_12);

        // Inputs churn during BUSY; only the latched read of line 5 is serviced.
        transact(32'h0000_00A0, PAT_C3, 1'b1, 1'b0, rd, first_ack, n_ack);
        transact(32'h0000_00A0, '0, 1'b0, 1'b1, rd, first_ack, n_ack);
        check_eq("busy_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("busy_nack", 256'(n_ack), 256'(1));
        check_eq("busy_data", rd, PAT_C3);
        check_eq("busy_line5", dut.mem[5], PAT_C3);
        check_eq("busy_line3", dut.mem[3], PAT_A5);
        check_eq("busy_line4", dut.mem[4], PAT_12);

        // 0x4060 -> line 0x203, aliases to line 3 with 512 lines.
        transact(32'h0000_4060, '0, 1'b0, 1'b0, rd, first_ack, n_ack);
        check_eq("alias_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("alias_data", rd, PAT_A5);

        // Held enable: accepts at k = 0, 12, 24; acks observed after edges 10, 22, 34.
        bus.addr   = 32'h0000_0060;
        bus.write  = 1'b0;
        bus.enable = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            bit exp_ack;
            tick();
            exp_ack = (k % 12 == 10) && (k <= 34);
            check_eq($sformatf("held_ack_k%0d", k), 256'(bus.ack), 256'(exp_ack));
            if (exp_ack) begin
                check_eq($sformatf("held_data_k%0d", k), bus.rdata, PAT_A5);
            end
            if (k == 34) begin
                bus.enable = 1'b0;
            end
        end

        // Reset halfway through a write to line 7: no ack and old contents kept.
        transact(32'h0000_00E0, PAT_77, 1'b1, 1'b0, rd, first_ack, n_ack);
        check_eq("line7_pre_nack", 256'(n_ack), 256'(1));
        bus.addr   = 32'h0000_00E0;
        bus.wdata  = PAT_FF;
        bus.write  = 1'b1;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_ack", 256'(bus.ack), 256'(0));
        check_eq("midrst_rdata", bus.rdata, '0);
        @(posedge clk);
        tick();
        rst = 1'b0;
        acks_after = 0;
        for (int k = 0; k < int'(LATENCY) + 4; k++) begin
            tick();
            if (bus.ack === 1'b1) begin
                acks_after++;
            end
        end
        check_eq("midrst_no_ack", 256'(acks_after), 256'(0));
        check_eq("midrst_line7", dut.mem[7], PAT_77);

        transact(32'h0000_00E0, '0, 1'b0, 1'b0, rd, first_ack, n_ack);
        check_eq("postrst_lat", 256'(first_ack), 256'(LATENCY));
        check_eq("postrst_nack", 256'(n_ack), 256'(1));
        check_eq("postrst_data", rd, PAT_77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_data_memory.md
# line_data_memory

Line-granular main-memory model sitting directly downstream of the data cache controller in the pipelined CPU. It consumes the controller's 256-bit line requests (address, enable, write, write data) and returns read lines with a one-cycle acknowledge after a fixed, parameterised access latency. It serves one request at a time and ignores new requests while busy, so the cache controller sees the same enable/ack handshake it expects from main memory.

## Interface
- LATENCY, 10, cycles from request acceptance to ack; legal range 1..255
- DEPTH, 512, number of 256-bit lines (power of two); IDX_W = log2(DEPTH)
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; asynchronous, active-high
- addr_i  input  32  byte address of line; bits [4:0] ignored
- data_i  input  256  write line data
- enable_i  input  1  request valid
- write_i  input  1  1 = write line, 0 = read line; sampled with enable_i
- ack_o  output  1  registered; high exactly one cycle per completed request
- data_o  output  256  registered read data; valid while ack_o high on reads, holds value otherwise

## Operation
- Storage: DEPTH x 256-bit array. Line index = addr[IDX_W+4:5]; higher address bits are discarded (addresses alias modulo DEPTH lines).
- FSM states: IDLE, BUSY, ACK.
- IDLE: if enable_i=1 at a rising edge, latch addr_i index, data_i, write_i; load counter with LATENCY-1; go to BUSY (or directly to ACK when LATENCY=1). Otherwise stay.
- BUSY: decrement counter each edge; when counter reaches 0 on an edge, perform access and go to ACK.
  - Read: data_o <= array[index] on that edge.
  - Write: array[index] <= latched data; data_o unchanged.
- ACK: ack_o=1 for this one cycle; next edge returns to IDLE unconditionally. No request is accepted during ACK.
- enable_i, write_i, addr_i, data_i are ignored in BUSY and ACK; only the latched copies are used. Changing inputs mid-transaction has no effect.
- If enable_i is still high in the first IDLE cycle after ACK, it is accepted as a new request; the controller must drop enable_i in the cycle it observes ack_o.
- Read and write to the same line back-to-back: the read returns the written data (write completes before ACK).
- Array contents are never cleared by logic; the bench preloads/inspects via hierarchical access.

## Timing
- Request sampled at edge E0 (in IDLE): ack_o rises after edge E0+LATENCY, is high for exactly one cycle, falls after edge E0+LATENCY+1.
- Minimum spacing of accepted requests: LATENCY+2 edges (accept, LATENCY cycles, back through IDLE).
- Counter width 8 bits; no wrap possible within legal LATENCY.
- Reset (asserted at any time, including mid-BUSY or in ACK): immediately state=IDLE, ack_o=0, data_o=0, counter=0, latched request discarded; a pending write is not performed; array untouched. First request accepted at the first rising edge after rst_i deasserts with enable_i=1.
- No combinational path from inputs to outputs.

## Test plan
- Reset values: assert rst_i mid-cycle with no clock edge -> ack_o=0 and data_o=0 immediately; state IDLE.
- Read latency: preload line 3 = 256'hA5..A5, LATENCY=10, request addr 32'h0000_0060 read at E0 -> ack_o high only in cycle after E0+10, data_o=A5..A5; ack_o low before and after.
- Write then read: write addr 32'h0000_0080 data 256'h1234..., then read same address -> second ack returns 256'h1234...; data_o unchanged (old value) during the write's ack cycle.
- Busy-ignore and aliasing: during BUSY toggle enable_i/addr_i/write_i -> only original request serviced, exactly one ack; with DEPTH=512, read addr 32'h0000_4060 returns line 3 contents.
- Held enable: keep enable_i high continuously for reads -> acks spaced LATENCY+2 cycles apart, each one cycle wide.
- Reset mid-write: start write to line 7, assert rst_i at cycle 5 of 10 -> no ack, line 7 retains old contents, next read of line 7 completes normally with full LATENCY.
